dmem_port_arbiter: RTL and testbench

Sequences the single-port data SRAM (32×1024, active-low chip select and write enable, one-cycle read latency) between two requesters: the pipeline MEM stage (primary) and a debug/loader port (secondary, req/gnt handshake). It sits between the MEM stage and the SRAM macro and owns every SRAM control pin. It tracks the owner of each outstanding read so the returned word goes to the right requester. An optional starvation guard forces a debug slot and stalls the pipeline for one cycle.

---
 rtl/dmem_port_arbiter_pkg.sv | 13 +
 rtl/dmem_starve_cnt.sv | 32 +++
 rtl/dmem_port_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default widths for the data-SRAM port arbiter.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_PIPE,
    RESP_DBG
  } resp_owner_e;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive denied debug cycles; raises force_dbg once
// the debug port has waited MAX_WAIT-1 cycles and the pipeline still competes.
module dmem_starve_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic pipe_req,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_dbg
);

  localparam int CntW = $clog2(MAX_WAIT);
  localparam logic [CntW-1:0] CntSat = CntW'(MAX_WAIT - 1);

  logic [CntW-1:0] cnt;

  // A withdrawn or granted request starts the wait over from zero.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      cnt <= '0;
    end else if (cnt != CntSat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_dbg = (cnt == CntSat) && dbg_req && pipe_req;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data SRAM between the MEM stage and the debug port.
// Define DMEM_ARB_STARVE_EN to enable the debug starvation guard.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              pipe_csb,
  input  logic              pipe_web,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_din,
  output logic              pipe_stall,
  output logic              pipe_rvalid,
  output logic [DATA_W-1:0] pipe_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_csb0,
  output logic              mem_web0,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [DATA_W-1:0] mem_din0,
  input  logic [DATA_W-1:0] mem_dout0
);

  if (MAX_WAIT < 2) begin : g_max_wait_check
    $error("dmem_port_arbiter: MAX_WAIT must be at least 2");
  end

  logic        pipe_req;
  logic        dbg_want;
  logic        pipe_gnt;
  resp_owner_e resp_state;

  // Requests are masked during reset so every grant and SRAM pin sits idle.
  assign pipe_req = RSTn & ~pipe_csb;
  assign dbg_want = RSTn & dbg_req;

`ifdef DMEM_ARB_STARVE_EN
  logic force_dbg;

  dmem_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .pipe_req  (pipe_req),
    .dbg_req   (dbg_want),
    .dbg_gnt   (dbg_gnt),
    .force_dbg (force_dbg)
  );

  assign pipe_stall = pipe_req & force_dbg;
  assign dbg_gnt    = dbg_want & (~pipe_req | force_dbg);
`else
  assign pipe_stall = 1'b0;
  assign dbg_gnt    = dbg_want & ~pipe_req;
`endif

  assign pipe_gnt = pipe_req & ~pipe_stall;

  always_comb begin
    mem_csb0  = 1'b1;
    mem_web0  = 1'b1;
    mem_addr0 = '0;
    mem_din0  = '0;
    if (dbg_gnt) begin
      mem_csb0  = 1'b0;
      mem_web0  = ~dbg_we;
      mem_addr0 = dbg_addr;
      mem_din0  = dbg_wdata;
    end else if (pipe_gnt) begin
      mem_csb0  = 1'b0;
      mem_web0  = pipe_web;
      mem_addr0 = pipe_addr;
      mem_din0  = pipe_din;
    end
  end

  // Remembers who issued the read whose data appears on mem_dout0 next cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      resp_state <= RESP_NONE;
    end else if (dbg_gnt && !dbg_we) begin
      resp_state <= RESP_DBG;
    end else if (pipe_gnt && pipe_web) begin
      resp_state <= RESP_PIPE;
    end else begin
      resp_state <= RESP_NONE;
    end
  end

  assign pipe_rvalid = (resp_state == RESP_PIPE);
  assign dbg_rvalid  = (resp_state == RESP_DBG);
  assign pipe_rdata  = mem_dout0;
  assign dbg_rdata   = mem_dout0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural 1-cycle SRAM;
// expectations follow DMEM_ARB_STARVE_EN when it is defined.
module tb_dmem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        pipe_csb, pipe_web;
  logic [9:0]  pipe_addr;
  logic [31:0] pipe_din;
  logic        pipe_stall, pipe_rvalid;
  logic [31:0] pipe_rdata;
  logic        dbg_req, dbg_we;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_csb0, mem_web0;
  logic [9:0]  mem_addr0;
  logic [31:0] mem_din0;
  logic [31:0] mem_dout0 = '0;

  typedef struct {
    int          owner;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [31:0] sram [0:1023];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  dmem_port_arbiter #(.MAX_WAIT(4), .ADDR_W(10), .DATA_W(32)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .pipe_csb    (pipe_csb),
    .pipe_web    (pipe_web),
    .pipe_addr   (pipe_addr),
    .pipe_din    (pipe_din),
    .pipe_stall  (pipe_stall),
    .pipe_rvalid (pipe_rvalid),
    .pipe_rdata  (pipe_rdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .mem_csb0    (mem_csb0),
    .mem_web0    (mem_web0),
    .mem_addr0   (mem_addr0),
    .mem_din0    (mem_din0),
    .mem_dout0   (mem_dout0)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    if (!mem_csb0) begin
      if (!mem_web0) sram[mem_addr0] <= mem_din0;
      else mem_dout0 <= sram[mem_addr0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one cycle of requests, queues any expected read response and checks the grant outputs.
  task automatic applyStimulus(input string tag,
                               input logic pcsb, input logic pweb, input logic [9:0] paddr, input logic [31:0] pdin,
                               input logic dreq, input logic dwe, input logic [9:0] daddr, input logic [31:0] dwd,
                               input logic xgnt, input logic xstall, input logic xcsb, input logic xweb,
                               input logic [9:0] xaddr, input logic [31:0] xdin,
                               input int xowner, input logic [31:0] xdata);
    @(posedge CLK);
    #1;
    pipe_csb = pcsb; pipe_web = pweb; pipe_addr = paddr; pipe_din = pdin;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    if (xowner != 0) expq.push_back('{owner: xowner, data: xdata, cyc: cyc + 1});
    #3;
    checkOutput({tag, "_dbg_gnt"}, {31'b0, dbg_gnt}, {31'b0, xgnt});
    checkOutput({tag, "_pipe_stall"}, {31'b0, pipe_stall}, {31'b0, xstall});
    checkOutput({tag, "_mem_csb0"}, {31'b0, mem_csb0}, {31'b0, xcsb});
    checkOutput({tag, "_mem_web0"}, {31'b0, mem_web0}, {31'b0, xweb});
    checkOutput({tag, "_mem_addr0"}, {22'b0, mem_addr0}, {22'b0, xaddr});
    checkOutput({tag, "_mem_din0"}, mem_din0, xdin);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_mem_csb0"}, {31'b0, mem_csb0}, 32'd1);
    checkOutput({tag, "_mem_web0"}, {31'b0, mem_web0}, 32'd1);
    checkOutput({tag, "_mem_addr0"}, {22'b0, mem_addr0}, 32'd0);
    checkOutput({tag, "_mem_din0"}, mem_din0, 32'd0);
    checkOutput({tag, "_dbg_gnt"}, {31'b0, dbg_gnt}, 32'd0);
    checkOutput({tag, "_pipe_stall"}, {31'b0, pipe_stall}, 32'd0);
    checkOutput({tag, "_pipe_rvalid"}, {31'b0, pipe_rvalid}, 32'd0);
    checkOutput({tag, "_dbg_rvalid"}, {31'b0, dbg_rvalid}, 32'd0);
  endtask

  // Monitor: every rvalid must match the oldest queued response, on its exact cycle.
  always @(negedge CLK) begin
    if (pipe_rvalid || dbg_rvalid) begin
      if (pipe_rvalid && dbg_rvalid) begin
        checkOutput("rvalid_both", 32'd1, 32'd0);
      end else if (expq.size() == 0) begin
        checkOutput("rvalid_unexpected", {30'b0, dbg_rvalid, pipe_rvalid}, 32'd0);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("resp_owner", pipe_rvalid ? 32'd1 : 32'd2, mon_e.owner);
        checkOutput("resp_data", pipe_rvalid ? pipe_rdata : dbg_rdata, mon_e.data);
        checkOutput("resp_cycle", cyc, mon_e.cyc);
      end
    end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
      mon_e = expq.pop_front();
      checkOutput("resp_missing", 32'd0, mon_e.owner);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    sram[10'h01c] = 32'h0000_0002;
    sram[10'h010] = 32'h1111_1111;
    sram[10'h020] = 32'h2222_2222;

    RSTn = 1'b0;
    pipe_csb = 1'b0; pipe_web = 1'b1; pipe_addr = 10'h01c; pipe_din = 32'hA5A5_A5A5;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h3ff; dbg_wdata = 32'h1234_5678;
    @(posedge CLK);
    #4;
    checkIdleOutputs("reset");
    pipe_csb = 1'b1; pipe_din = '0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_wdata = '0;
    RSTn = 1'b1;

    applyStimulus("pipe_rd", 0,1,10'h01c,0, 0,0,10'h000,0, 0,0,0,1,10'h01c,0, 1,32'h0000_0002);
    applyStimulus("idle0",   1,1,10'h000,0, 0,0,10'h000,0, 0,0,1,1,10'h000,0, 0,0);
    applyStimulus("dbg_wr",  1,1,10'h000,0, 1,1,10'h3ff,32'hDEAD_BEEF, 1,0,0,0,10'h3ff,32'hDEAD_BEEF, 0,0);
    applyStimulus("dbg_rd",  1,1,10'h000,0, 1,0,10'h3ff,0, 1,0,0,1,10'h3ff,0, 2,32'hDEAD_BEEF);
    applyStimulus("idle1",   1,1,10'h000,0, 0,0,10'h000,0, 0,0,1,1,10'h000,0, 0,0);

    for (int k = 1; k <= 6; k++) begin
`ifdef DMEM_ARB_STARVE_EN
      if (k < 4)
        applyStimulus("starve_wait",  0,1,10'h010,0, 1,0,10'h020,0, 0,0,0,1,10'h010,0, 1,32'h1111_1111);
      else if (k == 4)
        applyStimulus("starve_force", 0,1,10'h010,0, 1,0,10'h020,0, 1,1,0,1,10'h020,0, 2,32'h2222_2222);
      else
        applyStimulus("starve_after", 0,1,10'h010,0, 0,0,10'h000,0, 0,0,0,1,10'h010,0, 1,32'h1111_1111);
`else
      applyStimulus("strict_pipe", 0,1,10'h010,0, 1,0,10'h020,0, 0,0,0,1,10'h010,0, 1,32'h1111_1111);
`endif
    end

    applyStimulus("alt_pipe_rd", 0,1,10'h01c,0, 0,0,10'h000,0, 0,0,0,1,10'h01c,0, 1,32'h0000_0002);
    applyStimulus("alt_dbg_rd",  1,1,10'h000,0, 1,0,10'h020,0, 1,0,0,1,10'h020,0, 2,32'h2222_2222);
    applyStimulus("alt_pipe_wr", 0,0,10'h030,32'h0000_0005, 0,0,10'h000,0, 0,0,0,0,10'h030,32'h0000_0005, 0,0);
    applyStimulus("pipe_rd_back",0,1,10'h030,0, 0,0,10'h000,0, 0,0,0,1,10'h030,0, 1,32'h0000_0005);
    applyStimulus("idle2",       1,1,10'h000,0, 0,0,10'h000,0, 0,0,1,1,10'h000,0, 0,0);

    // Debug read granted, then reset pulsed before the edge that would return it.
    applyStimulus("rst_dbg_rd",  1,1,10'h000,0, 1,0,10'h3ff,0, 1,0,0,1,10'h3ff,0, 0,0);
    RSTn = 1'b0;
    #2;
    checkIdleOutputs("rst_mid");
    @(posedge CLK);
    #1;
    checkIdleOutputs("rst_hold");
    dbg_req = 1'b0;
    #3;
    RSTn = 1'b1;
    applyStimulus("post_rst_idle", 1,1,10'h000,0, 0,0,10'h000,0, 0,0,1,1,10'h000,0, 0,0);
    applyStimulus("post_rst_rd",   0,1,10'h01c,0, 0,0,10'h000,0, 0,0,0,1,10'h01c,0, 1,32'h0000_0002);
    applyStimulus("idle3",         1,1,10'h000,0, 0,0,10'h000,0, 0,0,1,1,10'h000,0, 0,0);
    @(negedge CLK);
    #1;
    checkOutput("queue_drained", expq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
